// File: rtl/id_stage_pkg.sv
// rtl/id_stage_pkg.sv - opcode/funct constants, ALU encoding and control bundle for id_stage
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_LUI = 4'd9
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch_eq;
    logic    branch_ne;
    logic    jump;
    logic    illegal;
  } ctrl_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// rtl/id_stage_if.sv - fetch, writeback and ID/EX signal bundle for id_stage
interface id_stage_if #(parameter int PC_W = 8);

  logic [31:0]     inst_code;
  logic [PC_W-1:0] pc_in;
  logic            in_valid;
  logic            stall;
  logic            flush;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [31:0]     wb_data;

  logic            out_valid;
  logic [PC_W-1:0] id_pc;
  logic [31:0]     rs_data;
  logic [31:0]     rt_data;
  logic [31:0]     imm_ext;
  logic [4:0]      rd_addr;
  logic [3:0]      alu_op;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic            branch_eq;
  logic            branch_ne;
  logic            jump;
  logic [PC_W-1:0] jump_target;
  logic            illegal;

  modport master (
    output inst_code, pc_in, in_valid, stall, flush, wb_en, wb_addr, wb_data,
    input  out_valid, id_pc, rs_data, rt_data, imm_ext, rd_addr, alu_op,
           reg_write, mem_read, mem_write, branch_eq, branch_ne, jump,
           jump_target, illegal
  );

  modport slave (
    input  inst_code, pc_in, in_valid, stall, flush, wb_en, wb_addr, wb_data,
    output out_valid, id_pc, rs_data, rt_data, imm_ext, rd_addr, alu_op,
           reg_write, mem_read, mem_write, branch_eq, branch_ne, jump,
           jump_target, illegal
  );

endinterface

// File: rtl/id_stage_regfile.sv
// rtl/id_stage_regfile.sv - 32x32 register file, $0 hardwired; ID_STAGE_BYPASS_EN forwards same-edge writes
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (we && wa != 5'd0) regs_d[wa] = wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  always_comb begin
    rd1 = (ra1 == 5'd0) ? 32'd0 : regs_q[ra1];
    rd2 = (ra2 == 5'd0) ? 32'd0 : regs_q[ra2];
`ifdef ID_STAGE_BYPASS_EN
    // Forward the in-flight write so the consumer sees it on the same edge
    if (we && wa != 5'd0 && wa == ra1) rd1 = wd;
    if (we && wa != 5'd0 && wa == ra2) rd2 = wd;
`endif
  end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - MIPS-subset decode, register read and ID/EX register; option macro ID_STAGE_BYPASS_EN
module id_stage
  import id_pkg::*;
#(
  parameter int PC_W = 8
) (
  input logic     clk,
  input logic     rst,
  id_stage_if.slave bus
);

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  assign op    = bus.inst_code[31:26];
  assign rs    = bus.inst_code[25:21];
  assign rt    = bus.inst_code[20:16];
  assign rd    = bus.inst_code[15:11];
  assign shamt = bus.inst_code[10:6];
  assign funct = bus.inst_code[5:0];
  assign imm   = bus.inst_code[15:0];

  logic [31:0] rs_rd, rt_rd;

  regfile u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rs_rd),
    .rd2 (rt_rd),
    .we  (bus.wb_en),
    .wa  (bus.wb_addr),
    .wd  (bus.wb_data)
  );

  ctrl_t       ctrl_dec;
  logic [31:0] imm_dec;
  logic [4:0]  rd_dec;

  always_comb begin
    ctrl_dec = '0;
    imm_dec  = '0;
    rd_dec   = '0;
    unique case (op)
      OP_RTYPE: begin
        rd_dec             = rd;
        imm_dec            = {27'd0, shamt};
        ctrl_dec.reg_write = 1'b1;
        case (funct)
          FN_ADD:  ctrl_dec.alu_op = ALU_ADD;
          FN_SUB:  ctrl_dec.alu_op = ALU_SUB;
          FN_AND:  ctrl_dec.alu_op = ALU_AND;
          FN_OR:   ctrl_dec.alu_op = ALU_OR;
          FN_XOR:  ctrl_dec.alu_op = ALU_XOR;
          FN_NOR:  ctrl_dec.alu_op = ALU_NOR;
          FN_SLT:  ctrl_dec.alu_op = ALU_SLT;
          FN_SLL:  ctrl_dec.alu_op = ALU_SLL;
          FN_SRL:  ctrl_dec.alu_op = ALU_SRL;
          default: ctrl_dec.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_LW: begin
        rd_dec             = rt;
        imm_dec            = sign_ext16(imm);
        ctrl_dec.alu_op    = ALU_ADD;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.mem_read  = (op == OP_LW);
      end
      OP_SW: begin
        rd_dec             = rt;
        imm_dec            = sign_ext16(imm);
        ctrl_dec.alu_op    = ALU_ADD;
        ctrl_dec.mem_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        rd_dec             = rt;
        imm_dec            = sign_ext16(imm);
        ctrl_dec.alu_op    = ALU_SUB;
        ctrl_dec.branch_eq = (op == OP_BEQ);
        ctrl_dec.branch_ne = (op == OP_BNE);
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        rd_dec             = rt;
        imm_dec            = {16'd0, imm};
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_op    = (op == OP_ANDI) ? ALU_AND :
                             (op == OP_ORI)  ? ALU_OR  : ALU_XOR;
      end
      OP_LUI: begin
        rd_dec             = rt;
        imm_dec            = {imm, 16'd0};
        ctrl_dec.alu_op    = ALU_LUI;
        ctrl_dec.reg_write = 1'b1;
      end
      OP_J: ctrl_dec.jump = 1'b1;
      OP_JAL: begin
        rd_dec             = 5'd31;
        ctrl_dec.jump      = 1'b1;
        ctrl_dec.reg_write = 1'b1;
      end
      default: ctrl_dec.illegal = 1'b1;
    endcase
    // An undecodable word must never cause side effects downstream
    if (ctrl_dec.illegal) begin
      ctrl_dec.reg_write = 1'b0;
      ctrl_dec.mem_read  = 1'b0;
      ctrl_dec.mem_write = 1'b0;
      ctrl_dec.branch_eq = 1'b0;
      ctrl_dec.branch_ne = 1'b0;
      ctrl_dec.jump      = 1'b0;
    end
  end

  logic            valid_q, valid_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     rs_data_q, rs_data_d;
  logic [31:0]     rt_data_q, rt_data_d;
  logic [31:0]     imm_q, imm_d;
  logic [4:0]      rd_q, rd_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [PC_W-1:0] jt_q, jt_d;

  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rd_d      = rd_q;
    ctrl_d    = ctrl_q;
    jt_d      = jt_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (!bus.stall) begin
      valid_d   = bus.in_valid;
      pc_d      = bus.pc_in;
      rs_data_d = rs_rd;
      rt_data_d = rt_rd;
      imm_d     = imm_dec;
      rd_d      = rd_dec;
      ctrl_d    = ctrl_dec;
      jt_d      = {bus.inst_code[PC_W-3:0], 2'b00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
      ctrl_q    <= '0;
      jt_q      <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rd_q      <= rd_d;
      ctrl_q    <= ctrl_d;
      jt_q      <= jt_d;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.id_pc       = pc_q;
  assign bus.rs_data     = rs_data_q;
  assign bus.rt_data     = rt_data_q;
  assign bus.imm_ext     = imm_q;
  assign bus.rd_addr     = rd_q;
  assign bus.alu_op      = ctrl_q.alu_op;
  assign bus.reg_write   = ctrl_q.reg_write;
  assign bus.mem_read    = ctrl_q.mem_read;
  assign bus.mem_write   = ctrl_q.mem_write;
  assign bus.branch_eq   = ctrl_q.branch_eq;
  assign bus.branch_ne   = ctrl_q.branch_ne;
  assign bus.jump        = ctrl_q.jump;
  assign bus.jump_target = jt_q;
  assign bus.illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed self-checking bench for id_stage
module tb_id_stage;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  id_stage_if #(.PC_W(8)) bus ();

  id_stage #(.PC_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

`ifdef ID_STAGE_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'h0000_0005;
`else
  localparam logic [31:0] BYP_EXP = 32'h0000_FFFF;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] inst, input logic [7:0] pc);
    bus.inst_code = inst;
    bus.pc_in     = pc;
    bus.in_valid  = 1'b1;
  endtask

  logic [31:0] held_imm;

  initial begin
    rst           = 1'b1;
    bus.inst_code = '0;
    bus.pc_in     = '0;
    bus.in_valid  = 1'b0;
    bus.stall     = 1'b0;
    bus.flush     = 1'b0;
    bus.wb_en     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    #2;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_illegal",   {31'd0, bus.illegal},   32'd0);
    chk("rst_alu_op",    {28'd0, bus.alu_op},    32'd0);
    chk("rst_reg_write", {31'd0, bus.reg_write}, 32'd0);
    chk("rst_rs_data",   bus.rs_data,            32'd0);
    step();
    rst = 1'b0;

    // sll $0,$0,0
    load(32'h0000_0000, 8'h04);
    step();
    chk("nop_valid",     {31'd0, bus.out_valid}, 32'd1);
    chk("nop_alu_op",    {28'd0, bus.alu_op},    32'd7);
    chk("nop_reg_write", {31'd0, bus.reg_write}, 32'd1);
    chk("nop_rd_addr",   {27'd0, bus.rd_addr},   32'd0);
    chk("nop_pc",        {24'd0, bus.id_pc},     32'h04);

    // $8 = 0x0000FFFF, no instruction
    bus.in_valid = 1'b0;
    bus.wb_en    = 1'b1;
    bus.wb_addr  = 5'd8;
    bus.wb_data  = 32'h0000_FFFF;
    step();
    chk("idle_valid", {31'd0, bus.out_valid}, 32'd0);

    // attempt to write $0, load andi $9,$8,0xFFF0
    bus.wb_addr = 5'd0;
    bus.wb_data = 32'hDEAD_BEEF;
    load(32'h3109_FFF0, 8'h08);
    step();
    bus.wb_en = 1'b0;
    chk("andi_rs",     bus.rs_data,            32'h0000_FFFF);
    chk("andi_imm",    bus.imm_ext,            32'h0000_FFF0);
    chk("andi_rd",     {27'd0, bus.rd_addr},   32'd9);
    chk("andi_alu_op", {28'd0, bus.alu_op},    32'd2);

    // lw $10,-4($8)
    load(32'h8D0A_FFFC, 8'h0C);
    step();
    chk("lw_imm",       bus.imm_ext,            32'hFFFF_FFFC);
    chk("lw_mem_read",  {31'd0, bus.mem_read},  32'd1);
    chk("lw_reg_write", {31'd0, bus.reg_write}, 32'd1);
    chk("lw_rd",        {27'd0, bus.rd_addr},   32'd10);
    chk("lw_alu_op",    {28'd0, bus.alu_op},    32'd0);

    // add $2,$0,$0 : $0 still reads zero after the write attempt
    load(32'h0000_1020, 8'h10);
    step();
    chk("r0_rs", bus.rs_data, 32'd0);
    chk("r0_rt", bus.rt_data, 32'd0);
    chk("r0_rd", {27'd0, bus.rd_addr}, 32'd2);

    // add $8,$8,$9 loaded on the edge that writes $8 = 5
    bus.wb_en   = 1'b1;
    bus.wb_addr = 5'd8;
    bus.wb_data = 32'h0000_0005;
    load(32'h0109_4020, 8'h14);
    step();
    bus.wb_en = 1'b0;
    chk("byp_rs",     bus.rs_data,         BYP_EXP);
    chk("byp_rt",     bus.rt_data,         32'd0);
    chk("byp_alu_op", {28'd0, bus.alu_op}, 32'd0);

    // lui $10,0x1234 then hold it with stall for 3 cycles
    load(32'h3C0A_1234, 8'h18);
    step();
    chk("lui_imm",    bus.imm_ext,         32'h1234_0000);
    chk("lui_alu_op", {28'd0, bus.alu_op}, 32'd9);
    held_imm = bus.imm_ext;
    bus.stall = 1'b1;
    load(32'hAD0A_0008, 8'h1C);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_imm",   bus.imm_ext,            held_imm);
      chk("stall_alu",   {28'd0, bus.alu_op},    32'd9);
      chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_pc",    {24'd0, bus.id_pc},     32'h18);
      chk("stall_mw",    {31'd0, bus.mem_write}, 32'd0);
    end
    bus.flush = 1'b1;
    step();
    chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    // beq $8,$0,-1 ; $8 now holds 5
    load(32'h1100_FFFF, 8'h20);
    step();
    chk("beq_beq", {31'd0, bus.branch_eq}, 32'd1);
    chk("beq_bne", {31'd0, bus.branch_ne}, 32'd0);
    chk("beq_imm", bus.imm_ext,            32'hFFFF_FFFF);
    chk("beq_rw",  {31'd0, bus.reg_write}, 32'd0);
    chk("beq_rs",  bus.rs_data,            32'd5);

    // opcode 0x3F is undecodable
    load(32'hFC00_0000, 8'h24);
    step();
    chk("ill_illegal", {31'd0, bus.illegal},   32'd1);
    chk("ill_valid",   {31'd0, bus.out_valid}, 32'd1);
    chk("ill_rw",      {31'd0, bus.reg_write}, 32'd0);
    chk("ill_mr",      {31'd0, bus.mem_read},  32'd0);
    chk("ill_mw",      {31'd0, bus.mem_write}, 32'd0);
    chk("ill_beq",     {31'd0, bus.branch_eq}, 32'd0);
    chk("ill_bne",     {31'd0, bus.branch_ne}, 32'd0);
    chk("ill_jump",    {31'd0, bus.jump},      32'd0);

    // jal 0x10
    load(32'h0C00_0010, 8'h28);
    step();
    chk("jal_jump",    {31'd0, bus.jump},        32'd1);
    chk("jal_rd",      {27'd0, bus.rd_addr},     32'd31);
    chk("jal_target",  {24'd0, bus.jump_target}, 32'h40);
    chk("jal_rw",      {31'd0, bus.reg_write},   32'd1);
    chk("jal_illegal", {31'd0, bus.illegal},     32'd0);

    // reset asserted mid-stall takes effect without a clock edge
    bus.stall = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_mid_rd",    {27'd0, bus.rd_addr},   32'd0);
    chk("rst_mid_jump",  {31'd0, bus.jump},      32'd0);
    step();
    rst       = 1'b0;
    bus.stall = 1'b0;

    // add $0,$8,$0 : register file was cleared by reset
    load(32'h0100_0020, 8'h2C);
    step();
    chk("post_rst_rs",    bus.rs_data,            32'd0);
    chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
